sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for blocks whose producer and consumer share one clock domain, avoiding the pointer-synchronisation cost of the dual-clock FIFO. It adds selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between same-domain pipeline stages and shares the memory-array style and DSIZE/ASIZE parametrisation of the existing FIFO family.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sync_fifomem.sv | 27 ++
 rtl/sync_fifo.sv | 113 +++++++++++
 tb/tb_sync_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the FIFO family.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int unsigned FWFT_STD = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Occupancy counter width: one extra bit so DEPTH itself is representable
  function automatic int unsigned cnt_width(input int unsigned asize);
    return asize + 1;
  endfunction

  // Number of entries addressed by an asize-bit pointer
  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

endpackage

// File: rtl/sync_fifomem.sv
// DSIZE x DEPTH storage: synchronous write port, asynchronous read port.
module sync_fifomem
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through, occupancy count,
// programmable almost flags and sticky overflow/underflow.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned FWFT       = FWFT_STD,
  parameter int unsigned AFULL_LVL  = (32'd1 << ASIZE) - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          winc,
  input  logic [DSIZE-1:0]              wdata,
  output logic                          wfull,
  output logic                          walmost_full,
  input  logic                          rinc,
  output logic [DSIZE-1:0]              rdata,
  output logic                          rempty,
  output logic                          ralmost_empty,
  output logic [cnt_width(ASIZE)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);
  localparam int unsigned CW    = cnt_width(ASIZE);

  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [ASIZE-1:0] raddr_q, raddr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en, rd_en;
  logic [DSIZE-1:0] mem_rdata;

  // Flags come from the count register only
  assign wfull         = (count_q == CW'(DEPTH));
  assign rempty        = (count_q == CW'(0));
  assign walmost_full  = (count_q >= CW'(AFULL_LVL));
  assign ralmost_empty = (count_q <= CW'(AEMPTY_LVL));
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

  assign wr_en = winc && !wfull;
  assign rd_en = rinc && !rempty;

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (wr_en) waddr_d = waddr_q + ASIZE'(1);
    if (rd_en) raddr_d = raddr_q + ASIZE'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (winc && wfull)  ovf_d = 1'b1;
    if (rinc && rempty) unf_d = 1'b1;
  end

  // State register with synchronous reset taking priority over requests
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Writes on a reset edge are dropped so stale data never lands in memory
  sync_fifomem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en && !rst),
    .waddr_i (waddr_q),
    .wdata_i (wdata),
    .raddr_i (raddr_q),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word presented directly; zero while nothing is stored
    assign rdata = rempty ? '0 : mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    // Registered read: capture the head word on each accepted pop
    always_ff @(posedge clk) begin
      if (rst)        rdata_q <= '0;
      else if (rd_en) rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and small random bench for sync_fifo in standard and FWFT modes.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       w0, r0, w1, r1;
  logic [7:0] d0, d1;
  logic       full0, af0, empty0, ae0, ovf0, unf0;
  logic       full1, af1, empty1, ae1, ovf1, unf1;
  logic [7:0] rd0, rd1;
  logic [4:0] cnt0, cnt1;

  int passed = 0;
  int total  = 0;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .winc(w0), .wdata(d0), .wfull(full0),
    .walmost_full(af0), .rinc(r0), .rdata(rd0), .rempty(empty0),
    .ralmost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .winc(w1), .wdata(d1), .wfull(full1),
    .walmost_full(af1), .rinc(r1), .rdata(rd1), .rempty(empty1),
    .ralmost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       afull;
    logic       aempty;
    logic       ovf;
    logic       unf;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step0(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    w0 = w; r0 = r; d0 = d;
    @(posedge clk);
    #1;
    w0 = 1'b0; r0 = 1'b0;
  endtask

  task automatic step1(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    w1 = w; r1 = r; d1 = d;
    @(posedge clk);
    #1;
    w1 = 1'b0; r1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_rd;
  logic       wr, rr, wok, rok;
  logic [7:0] dr;

  initial begin
    rst = 1'b1; w0 = 0; r0 = 0; d0 = 0; w1 = 0; r1 = 0; d1 = 0;

    // Fill / overrun / drain vectors for the standard-mode instance
    for (int i = 0; i < 16; i++)
      vecs[i] = '{w:1, r:0, d:8'(i), cnt:5'(i + 1), empty:0, full:(i == 15),
                  afull:(i + 1 >= 14), aempty:(i + 1 <= 2), ovf:0, unf:0, rd:8'h00};
    vecs[16] = '{w:1, r:0, d:8'hFF, cnt:5'd16, empty:0, full:1, afull:1, aempty:0,
                 ovf:1, unf:0, rd:8'h00};
    for (int k = 0; k < 16; k++)
      vecs[17 + k] = '{w:0, r:1, d:8'h00, cnt:5'(15 - k), empty:(k == 15), full:0,
                       afull:(15 - k >= 14), aempty:(15 - k <= 2), ovf:1, unf:0, rd:8'(k)};
    vecs[33] = '{w:0, r:1, d:8'h00, cnt:5'd0, empty:1, full:0, afull:0, aempty:1,
                 ovf:1, unf:1, rd:8'h0F};

    do_reset();
    #1;
    chk("rst rempty", empty0, 1);
    chk("rst ralmost_empty", ae0, 1);
    chk("rst count", cnt0, 0);
    chk("rst wfull", full0, 0);
    chk("rst walmost_full", af0, 0);
    chk("rst overflow", ovf0, 0);
    chk("rst underflow", unf0, 0);
    chk("rst rdata", rd0, 0);
    chk("rst fwft rdata", rd1, 0);
    chk("rst fwft rempty", empty1, 1);

    // FWFT: word shows with rempty falling, pop returns to zero
    step1(1, 0, 8'hA5);
    chk("fwft rempty after write", empty1, 0);
    chk("fwft rdata fallthrough", rd1, 8'hA5);
    step1(0, 1, 8'h00);
    chk("fwft rempty after pop", empty1, 1);
    chk("fwft rdata after pop", rd1, 8'h00);
    step1(1, 0, 8'h11);
    step1(1, 0, 8'h22);
    chk("fwft head", rd1, 8'h11);
    step1(0, 1, 8'h00);
    chk("fwft second", rd1, 8'h22);
    chk("fwft count", cnt1, 1);

    // Table-driven fill, overrun and drain
    for (int i = 0; i < 34; i++) begin
      step0(vecs[i].w, vecs[i].r, vecs[i].d);
      chk($sformatf("v%0d count", i), cnt0, vecs[i].cnt);
      chk($sformatf("v%0d rempty", i), empty0, vecs[i].empty);
      chk($sformatf("v%0d wfull", i), full0, vecs[i].full);
      chk($sformatf("v%0d walmost_full", i), af0, vecs[i].afull);
      chk($sformatf("v%0d ralmost_empty", i), ae0, vecs[i].aempty);
      chk($sformatf("v%0d overflow", i), ovf0, vecs[i].ovf);
      chk($sformatf("v%0d underflow", i), unf0, vecs[i].unf);
      chk($sformatf("v%0d rdata", i), rd0, vecs[i].rd);
    end

    // Simultaneous winc/rinc: empty, mid-level, full
    do_reset();
    step0(1, 1, 8'h50);
    chk("sim empty count", cnt0, 1);
    chk("sim empty underflow", unf0, 1);
    chk("sim empty overflow", ovf0, 0);
    for (int i = 1; i < 5; i++) step0(1, 0, 8'(8'h50 + i));
    chk("sim mid pre count", cnt0, 5);
    step0(1, 1, 8'h55);
    chk("sim mid count", cnt0, 5);
    chk("sim mid rdata", rd0, 8'h50);
    for (int i = 1; i < 6; i++) begin
      step0(0, 1, 8'h00);
      chk($sformatf("sim mid order %0d", i), rd0, 8'(8'h50 + i));
    end
    chk("sim mid drained", empty0, 1);
    for (int i = 0; i < 16; i++) step0(1, 0, 8'(8'h60 + i));
    chk("sim full pre", full0, 1);
    step0(1, 1, 8'hEE);
    chk("sim full count", cnt0, 15);
    chk("sim full wfull", full0, 0);
    chk("sim full rdata", rd0, 8'h60);
    chk("sim full overflow", ovf0, 1);
    for (int i = 1; i < 16; i++) begin
      step0(0, 1, 8'h00);
      chk($sformatf("sim full order %0d", i), rd0, 8'(8'h60 + i));
    end
    chk("sim full drained", empty0, 1);

    // Random interleaving around half occupancy with a queue model
    do_reset();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      step0(1, 0, 8'(8'hC0 + i));
      q.push_back(8'(8'hC0 + i));
    end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      dr = 8'($urandom_range(0, 255));
      wok = wr && (q.size() < 16);
      rok = rr && (q.size() > 0);
      exp_rd = 8'h00;
      if (rok) exp_rd = q.pop_front();
      if (wok) q.push_back(dr);
      step0(wr, rr, dr);
      chk($sformatf("rnd%0d count", i), cnt0, 32'(q.size()));
      if (rok) chk($sformatf("rnd%0d rdata", i), rd0, exp_rd);
    end
    while (q.size() > 0) begin
      exp_rd = q.pop_front();
      step0(0, 1, 8'h00);
      chk("rnd drain rdata", rd0, exp_rd);
    end
    chk("rnd drained", empty0, 1);

    // Reset mid-operation with a concurrent write
    do_reset();
    for (int i = 0; i < 9; i++) step0(1, 0, 8'(8'h90 + i));
    chk("midrst pre count", cnt0, 9);
    @(negedge clk);
    rst = 1'b1; w0 = 1'b1; d0 = 8'hBB;
    @(posedge clk);
    #1;
    rst = 1'b0; w0 = 1'b0;
    chk("midrst count", cnt0, 0);
    chk("midrst rempty", empty0, 1);
    chk("midrst rdata", rd0, 0);
    step0(1, 0, 8'h11);
    step0(0, 1, 8'h00);
    chk("midrst next word", rd0, 8'h11);
    chk("midrst empty after", empty0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
